udp_rx_port_filter: RTL and testbench

//  Parametrised successor to the single-port UDP header receiver. Parses the 8-byte UDP header from the

---
 rtl/udp_rx_port_filter.sv | 213 +++++++++++++++++++++
 tb/tb_udp_rx_port_filter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_port_filter.sv
// udp_rx_port_filter: parses the UDP header, matches (src,dst) against a NUM_PORTS table, forwards accepted payload with the table index.
// Latency: each payload byte is on m_data 1 cycle after it is accepted; drop/abort pulses follow the deciding byte by 1 cycle.
// Backpressure: none, input is never stalled and the consumer must take every m_valid byte. Define UDP_CSUM_CHECK_EN for checksum checking.
module udp_rx_port_filter #(
   parameter int NUM_PORTS = 4,
   parameter int IDX_W     = ($clog2(NUM_PORTS) > 0) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [7:0]             s_data,
   input  logic                   s_valid,
   input  logic                   s_last,
   input  logic                   ip_header_done,
   input  logic                   ip_header_valid,
   input  logic [15:0]            ip_pseudo_sum,
   input  logic [16*NUM_PORTS-1:0] port_src_tbl,
   input  logic [16*NUM_PORTS-1:0] port_dst_tbl,
   input  logic [NUM_PORTS-1:0]   port_en,
   output logic [7:0]             m_data,
   output logic                   m_valid,
   output logic                   m_last,
   output logic                   m_abort,
   output logic [IDX_W-1:0]       m_port_idx,
   output logic                   drop_pulse,
   output logic [1:0]             drop_code,
   output logic                   csum_err
);

   typedef enum logic [2:0] {IDLE, SRC, DST, LEN, CSUM, PAYLOAD, DISCARD} state_t;

   state_t           state;
   logic             second;      // second byte of a 2-byte header field is next
   logic [7:0]       hdr_hi;      // first (high) byte of the field being assembled
   logic [15:0]      src_port;
   logic [15:0]      remaining;   // payload bytes still to forward
   logic [15:0]      pair;
   logic             hit;
   logic [IDX_W-1:0] hit_idx;
   logic             last_pay;

   assign pair     = {hdr_hi, s_data};
   assign last_pay = s_valid && !ip_header_done && (state == PAYLOAD) && (remaining == 16'd1);

   // Parallel table match on the dst-low byte; lowest enabled matching entry wins
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (port_en[i] &&
             ((port_src_tbl[16*i +: 16] == 16'h0000) || (port_src_tbl[16*i +: 16] == src_port)) &&
             (port_dst_tbl[16*i +: 16] == pair)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Header parser / payload forwarder; all outputs registered, pulses last one cycle
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= IDLE;
         second     <= 1'b0;
         hdr_hi     <= 8'h00;
         src_port   <= 16'h0000;
         remaining  <= 16'h0000;
         m_data     <= 8'h00;
         m_valid    <= 1'b0;
         m_last     <= 1'b0;
         m_abort    <= 1'b0;
         m_port_idx <= '0;
         drop_pulse <= 1'b0;
         drop_code  <= 2'd0;
      end else begin
         m_valid    <= 1'b0;
         m_last     <= 1'b0;
         m_abort    <= 1'b0;
         drop_pulse <= 1'b0;
         if (s_valid) begin
            if (ip_header_done) begin
               // New header start always wins; an open payload is cut short
               hdr_hi <= s_data;
               second <= 1'b0;
               if (state == PAYLOAD) begin
                  m_abort    <= 1'b1;
                  drop_pulse <= 1'b1;
                  drop_code  <= 2'd3;
               end
               if (s_last) begin
                  drop_pulse <= 1'b1;
                  drop_code  <= 2'd3;
                  state      <= IDLE;
               end else begin
                  state <= SRC;
               end
            end else begin
               case (state)
                  IDLE: ;
                  SRC: begin
                     if (s_last) begin
                        drop_pulse <= 1'b1;
                        drop_code  <= 2'd3;
                        state      <= IDLE;
                     end else if (!ip_header_valid) begin
                        drop_pulse <= 1'b1;
                        drop_code  <= 2'd1;
                        state      <= DISCARD;
                     end else begin
                        src_port <= pair;
                        state    <= DST;
                     end
                  end
                  DST, LEN, CSUM: begin
                     if (s_last && !(state == CSUM && second && remaining == 16'd0)) begin
                        drop_pulse <= 1'b1;
                        drop_code  <= 2'd3;
                        state      <= IDLE;
                     end else if (!second) begin
                        hdr_hi <= s_data;
                        second <= 1'b1;
                     end else begin
                        second <= 1'b0;
                        if (state == DST) begin
                           if (hit) begin
                              m_port_idx <= hit_idx;
                              state      <= LEN;
                           end else begin
                              drop_pulse <= 1'b1;
                              drop_code  <= 2'd0;
                              state      <= DISCARD;
                           end
                        end else if (state == LEN) begin
                           if (pair < 16'd8) begin
                              drop_pulse <= 1'b1;
                              drop_code  <= 2'd2;
                              state      <= DISCARD;
                           end else begin
                              remaining <= pair - 16'd8;
                              state     <= CSUM;
                           end
                        end else begin
                           state <= (remaining == 16'd0) ? IDLE : PAYLOAD;
                        end
                     end
                  end
                  PAYLOAD: begin
                     if (remaining == 16'd1) begin
                        m_valid <= 1'b1;
                        m_data  <= s_data;
                        m_last  <= 1'b1;
                        state   <= s_last ? IDLE : DISCARD;
                     end else if (s_last) begin
                        m_abort    <= 1'b1;
                        drop_pulse <= 1'b1;
                        drop_code  <= 2'd3;
                        state      <= IDLE;
                     end else begin
                        m_valid   <= 1'b1;
                        m_data    <= s_data;
                        remaining <= remaining - 16'd1;
                     end
                  end
                  DISCARD: if (s_last) state <= IDLE;
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

`ifdef UDP_CSUM_CHECK_EN
   logic [15:0] csum_acc;
   logic [15:0] rx_csum;
   logic [15:0] byte_word;
   logic [15:0] csum_fin;
   logic        odd_byte;

   function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

   // Even-indexed bytes are word high halves, odd-indexed low halves; a lone last byte is padded low
   assign byte_word = odd_byte ? {8'h00, s_data} : {s_data, 8'h00};
   assign csum_fin  = oc_add(csum_acc, byte_word);

   // Running 1's-complement sum over pseudo header, UDP header and payload
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         csum_acc <= 16'h0000;
         rx_csum  <= 16'h0000;
         odd_byte <= 1'b0;
         csum_err <= 1'b0;
      end else begin
         csum_err <= 1'b0;
         if (s_valid && ip_header_done) begin
            csum_acc <= oc_add(ip_pseudo_sum, {s_data, 8'h00});
            odd_byte <= 1'b1;
         end else if (s_valid && (state inside {SRC, DST, LEN, CSUM, PAYLOAD})) begin
            csum_acc <= csum_fin;
            odd_byte <= ~odd_byte;
            if (state == CSUM && second) rx_csum <= pair;
            if (last_pay) csum_err <= !((csum_fin == 16'hFFFF) || (rx_csum == 16'h0000));
         end
      end
   end
`else
   logic unused_pseudo;
   assign unused_pseudo = ^{ip_pseudo_sum, last_pay};
   assign csum_err      = 1'b0;
`endif

endmodule

// File: tb/tb_udp_rx_port_filter.sv
// tb_udp_rx_port_filter: directed frames against udp_rx_port_filter with an expected-event queue.
// Latency: outputs sampled 1 time unit after the edge that took each byte; any output on an idle step is flagged.
// Backpressure: none in the design; the bench drives bytes with optional gaps.
module tb_udp_rx_port_filter;
   localparam logic [15:0] PSUM = 16'h1111;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic        ip_header_done = 1'b0;
   logic        ip_header_valid = 1'b1;
   logic [63:0] port_src_tbl = {16'h0000, 16'h1234, 16'h0000, 16'h1234};
   logic [63:0] port_dst_tbl = {16'h0000, 16'h0050, 16'h0050, 16'h0050};
   logic [3:0]  port_en = 4'b0001;
   logic [7:0]  m_data;
   logic        m_valid, m_last, m_abort, drop_pulse, csum_err;
   logic [1:0]  m_port_idx, drop_code;

   int          total = 0;
   int          bad = 0;
   logic [17:0] exp_q[$];
   logic [7:0]  frm[$];

   udp_rx_port_filter #(.NUM_PORTS(4)) dut (
      .aclk(aclk), .aresetn(aresetn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .ip_header_done(ip_header_done), .ip_header_valid(ip_header_valid), .ip_pseudo_sum(PSUM),
      .port_src_tbl(port_src_tbl), .port_dst_tbl(port_dst_tbl), .port_en(port_en),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_abort(m_abort),
      .m_port_idx(m_port_idx), .drop_pulse(drop_pulse), .drop_code(drop_code), .csum_err(csum_err)
   );

   always #5 aclk = ~aclk;

   // event word: kind[17:16] (0 data, 1 abort, 2 drop), last, csum_err, idx[13:10], code[9:8], data[7:0]
   function automatic logic [17:0] ev_data(input logic [7:0] d, input logic l, input logic [1:0] idx, input logic c);
      return {2'd0, l, c, 2'b00, idx, 2'd0, d};
   endfunction
   function automatic logic [17:0] ev_drop(input logic [1:0] c);
      return {2'd2, 6'd0, c, 8'h00};
   endfunction

   task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_ev(input string tag, input logic [17:0] obs);
      total++;
      assert (exp_q.size() != 0) else begin
         bad++;
         $error("FAIL %s unexpected observed=%h expected=none", tag, obs);
      end
      if (exp_q.size() != 0) chk(tag, obs, exp_q.pop_front());
   endtask

   // One clock: drive a byte (or idle), then check whatever the DUT produced for it
   task automatic step(input logic [7:0] d, input logic v, input logic l, input logic hd);
      s_data = d; s_valid = v; s_last = l; ip_header_done = hd;
      @(posedge aclk);
      #1;
      s_valid = 1'b0; s_last = 1'b0; ip_header_done = 1'b0;
      if (!v) chk("idle_quiet", {15'd0, m_valid, m_abort, drop_pulse}, 18'd0);
      if (m_valid) check_ev("data", ev_data(m_data, m_last, m_port_idx, csum_err));
      if (m_abort) check_ev("abort", {2'd1, 16'd0});
      if (drop_pulse) check_ev("drop", ev_drop(drop_code));
   endtask

   task automatic send(input int gap, input logic with_last);
      for (int i = 0; i < frm.size(); i++) begin
         step(frm[i], 1'b1, with_last && (i == frm.size() - 1), i == 0);
         for (int g = 0; g < gap && i < frm.size() - 1; g++) step(8'h00, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic end_frame(input string tag);
      repeat (3) step(8'h00, 1'b0, 1'b0, 1'b0);
      total++;
      assert (exp_q.size() == 0) else begin
         bad++;
         $error("FAIL %s missing_events=%0d expected=0", tag, exp_q.size());
      end
      exp_q.delete();
   endtask

   // Word-wise 1's-complement sum of pseudo header plus the first len bytes of frm
   function automatic logic [15:0] frame_sum();
      int          len;
      logic [16:0] a;
      logic [15:0] w;
      len = int'({frm[4], frm[5]});
      a = {1'b0, PSUM};
      for (int i = 0; i < len; i += 2) begin
         w = {frm[i], (i + 1 < len) ? frm[i+1] : 8'h00};
         a = {1'b0, a[15:0]} + {1'b0, w};
         a = {1'b0, a[15:0]} + {16'd0, a[16]};
      end
      return a[15:0];
   endfunction

   function automatic logic exp_cerr();
`ifdef UDP_CSUM_CHECK_EN
      return !((frame_sum() == 16'hFFFF) || ({frm[6], frm[7]} == 16'h0000));
`else
      return 1'b0;
`endif
   endfunction

   task automatic set_csum();
      logic [15:0] c;
      frm[6] = 8'h00; frm[7] = 8'h00;
      c = ~frame_sum();
      frm[6] = c[15:8]; frm[7] = c[7:0];
   endtask

   task automatic exp_good(input logic [1:0] idx);
      int len;
      len = int'({frm[4], frm[5]});
      for (int i = 8; i < len; i++)
         exp_q.push_back(ev_data(frm[i], i == len - 1, idx, (i == len - 1) ? exp_cerr() : 1'b0));
   endtask

   initial begin
      repeat (2) @(posedge aclk);
      #1;
      chk("reset_outputs", {1'b0, m_data, m_valid, m_last, m_abort, m_port_idx, drop_pulse, drop_code, csum_err}, 18'd0);
      aresetn = 1'b1;

      // basic accept, entry 0
      frm = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      exp_good(2'd0); send(0, 1'b1); end_frame("t1_basic");

      // wildcard entry 1 wins over 2; then only 2 enabled
      port_en = 4'b0110;
      exp_good(2'd1); send(0, 1'b1); end_frame("t2_idx1");
      port_en = 4'b0100;
      exp_good(2'd2); send(0, 1'b1); end_frame("t2_idx2");
      port_en = 4'b0001;

      // no match
      frm[3] = 8'h51;
      exp_q.push_back(ev_drop(2'd0)); send(0, 1'b1); end_frame("t3_nomatch");
      frm[3] = 8'h50;

      // short length, then drop_code must hold
      frm = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h06, 8'h00, 8'h00, 8'h11, 8'h22};
      exp_q.push_back(ev_drop(2'd2)); send(0, 1'b1); end_frame("t4_shortlen");
      chk("drop_code_hold", {16'd0, drop_code}, 18'd2);

      // IP header invalid
      frm = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      ip_header_valid = 1'b0;
      exp_q.push_back(ev_drop(2'd1)); send(0, 1'b1); end_frame("t5_ipinvalid");
      ip_header_valid = 1'b1;

      // payload truncated by s_last on 3rd payload byte
      frm = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE};
      exp_q.push_back(ev_data(8'hDE, 1'b0, 2'd0, 1'b0));
      exp_q.push_back(ev_data(8'hAD, 1'b0, 2'd0, 1'b0));
      exp_q.push_back({2'd1, 16'd0});
      exp_q.push_back(ev_drop(2'd3));
      send(0, 1'b1); end_frame("t6_trunc");

      // 3-cycle gaps and two pad bytes
      frm = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00};
      exp_good(2'd0); send(3, 1'b1); end_frame("t7_gaps_pad");

      // header-only datagram: nothing out
      frm = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h08, 8'h00, 8'h00};
      send(0, 1'b1); end_frame("t8_len8");

      // new header mid-payload aborts, then the new frame is accepted
      frm = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hDE};
      exp_q.push_back(ev_data(8'hDE, 1'b0, 2'd0, 1'b0));
      send(0, 1'b0);
      frm = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      exp_q.push_back({2'd1, 16'd0});
      exp_q.push_back(ev_drop(2'd3));
      exp_good(2'd0); send(0, 1'b1); end_frame("t9_restart");

      // s_last inside the header
      frm = '{8'h12, 8'h34, 8'h00};
      exp_q.push_back(ev_drop(2'd3)); send(0, 1'b1); end_frame("t10_hdr_trunc");

      // reset mid-datagram: outputs clear, rest of frame produces nothing
      frm = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hDE};
      exp_q.push_back(ev_data(8'hDE, 1'b0, 2'd0, 1'b0));
      send(0, 1'b0);
      aresetn = 1'b0;
      #1;
      chk("mid_reset_outputs", {1'b0, m_data, m_valid, m_last, m_abort, m_port_idx, drop_pulse, drop_code, csum_err}, 18'd0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      step(8'hAD, 1'b1, 1'b0, 1'b0);
      step(8'hBE, 1'b1, 1'b0, 1'b0);
      step(8'hEF, 1'b1, 1'b1, 1'b0);
      end_frame("t11_mid_reset");

      // checksum: correct, corrupted payload bit, odd-length payload
      frm = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      set_csum();
      exp_good(2'd0); send(0, 1'b1); end_frame("t12_csum_ok");
      frm[9] = frm[9] ^ 8'h01;
      exp_good(2'd0); send(0, 1'b1); end_frame("t12_csum_bad");
      frm = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0B, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'h00};
      set_csum();
      exp_good(2'd0); send(0, 1'b1); end_frame("t12_csum_odd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
